// File: rtl/mem_island_rsp_buffer.sv
// Credit-limited request throttle and no-backpressure response FIFO between a
// converter memory port and one memory island port.
module mem_island_rsp_buffer #(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4,
  parameter int FallThrough    = 0,
  localparam int CntW  = $clog2(MaxOutstanding + 1),
  localparam int StrbW = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 up_req_i,
  output logic                 up_gnt_o,
  input  logic [AddrWidth-1:0] up_addr_i,
  input  logic                 up_we_i,
  input  logic [DataWidth-1:0] up_wdata_i,
  input  logic [StrbW-1:0]     up_strb_i,
  output logic                 up_rvalid_o,
  input  logic                 up_rready_i,
  output logic [DataWidth-1:0] up_rdata_o,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbW-1:0]     mem_strb_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 err_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW:0]   MaxTotal = (CntW + 1)'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(MaxOutstanding - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [CntW-1:0]      inflight_q, inflight_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] fifo_mem [MaxOutstanding];

  logic [CntW:0] total;
  logic          credit_ok;
  logic          fifo_empty;
  logic          rsp_ok;
  logic          bypass;
  logic          push;
  logic          pop;

  assign total      = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
  assign credit_ok  = (total < MaxTotal) && !rst_i;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign rsp_ok     = mem_rvalid_i && (inflight_q != '0);
  // A fall-through response consumed in the same cycle never occupies a slot.
  assign bypass     = (FallThrough != 0) && fifo_empty && up_rready_i && rsp_ok;
  assign push       = rsp_ok && !bypass;
  assign pop        = !fifo_empty && up_rready_i;

  assign mem_req_o   = up_req_i && credit_ok;
  assign up_gnt_o    = mem_req_o && mem_gnt_i;
  assign mem_addr_o  = up_addr_i;
  assign mem_we_o    = up_we_i;
  assign mem_wdata_o = up_wdata_i;
  assign mem_strb_o  = up_strb_i;

  assign up_rvalid_o   = !fifo_empty || ((FallThrough != 0) && rsp_ok);
  assign up_rdata_o    = (!fifo_empty || (FallThrough == 0)) ? fifo_mem[rptr_q] : mem_rdata_i;
  assign outstanding_o = total[CntW-1:0];
  assign err_o         = err_q;

  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;
    case ({up_gnt_o, rsp_ok})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (mem_rvalid_i && (inflight_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_q      <= err_d;
    end
  end

  // Storage is data only; validity is tracked solely by the counters above.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= mem_rdata_i;
  end

endmodule

// File: doc/mem_island_rsp_buffer.md
# mem_island_rsp_buffer

Per-port request-throttle and response buffer between one memory-side port of an AXI-to-memory converter and one narrow or wide port of the memory island core. It limits the number of outstanding requests to a fixed credit count. Island responses, which have no backpressure, go into a local FIFO. The FIFO is drained upstream with a valid/ready handshake, so the converter may stall responses without losing data.

## Interface

Parameters:
- AddrWidth, 32, request address width
- DataWidth, 64, data width (multiple of 8)
- MaxOutstanding, 4, credits; max granted-but-not-consumed requests (>=1)
- FallThrough, 0, 1 = response passes combinationally when FIFO empty and ready

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- up_req_i  in  1  upstream request valid
- up_gnt_o  out  1  upstream request granted
- up_addr_i  in  AddrWidth  request address
- up_we_i  in  1  write enable
- up_wdata_i  in  DataWidth  write data
- up_strb_i  in  DataWidth/8  byte strobes
- up_rvalid_o  out  1  response valid
- up_rready_i  in  1  response ready
- up_rdata_o  out  DataWidth  response data
- mem_req_o  out  1  island request
- mem_gnt_i  in  1  island grant
- mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o  out  AddrWidth/1/DataWidth/DataWidth/8  forwarded request fields
- mem_rvalid_i  in  1  island response valid (one per granted request, reads and writes, in order)
- mem_rdata_i  in  DataWidth  island response data
- outstanding_o  out  $clog2(MaxOutstanding+1)  inflight + buffered count
- err_o  out  1  sticky: unexpected response dropped

## Operation

- Counters:
  - inflight: requests granted by the island, response not yet returned.
  - fifo_cnt: responses buffered.
  - total = inflight + fifo_cnt, never exceeds MaxOutstanding.
- Credit: credit_ok = (total < MaxOutstanding) && !rst_i.
- Request path:
  - mem_req_o = up_req_i && credit_ok.
  - up_gnt_o = mem_req_o && mem_gnt_i.
  - Address, we, wdata and strb forwarded unregistered.
- Grant (up_gnt_o=1): inflight += 1.
- mem_rvalid_i with inflight>0: inflight -= 1; mem_rdata_i pushed to FIFO (depth MaxOutstanding).
  - Overflow is impossible by construction.
- mem_rvalid_i with inflight==0: response dropped, err_o set to 1 (sticky until reset).
- Grant and response in the same cycle: inflight unchanged; the push still occurs.
- Upstream pop: up_rvalid_o && up_rready_i; fifo_cnt -= 1.
  - Push and pop in the same cycle: fifo_cnt unchanged; order preserved.
- up_rvalid_o = fifo_cnt>0.
  - If FallThrough=1: up_rvalid_o = fifo_cnt>0 || (mem_rvalid_i && inflight>0).
  - If FallThrough=1, FIFO empty and up_rready_i=1: the response is consumed directly and not written.
- up_rdata_o = FIFO head, or mem_rdata_i in the fall-through case.
  - Held stable while up_rvalid_o && !up_rready_i.
- Credits are released on upstream pop, not on island response.
- Reset clears inflight, the FIFO and err_o.
  - A response returning after a mid-operation reset is dropped and flags err_o.
  - The integrator quiesces the port before reset.

## Timing

- Reset values:
  - up_gnt_o=0, mem_req_o=0, up_rvalid_o=0, outstanding_o=0, err_o=0.
  - up_rdata_o don't-care.
- Request path: 0-cycle combinational; grant in the same cycle as mem_gnt_i.
- Response latency, FallThrough=0: mem_rvalid_i in cycle N gives up_rvalid_o from cycle N+1.
- Response latency, FallThrough=1: cycle N when the FIFO is empty.
- Credit return: a pop in cycle N allows a new mem_req_o in cycle N+1 (registered counters, no same-cycle reuse).
- Full credit (total==MaxOutstanding): mem_req_o=0 regardless of up_req_i.
- outstanding_o registered; reflects state after the previous edge.
- err_o registered; rises the cycle after the offending mem_rvalid_i.

## Test plan

- Single read, mem_gnt_i=1 immediately, mem_rvalid_i one cycle later with data 0xDEAD_BEEF, up_rready_i=1, FallThrough=0 -> up_rvalid_o one cycle after mem_rvalid_i with rdata 0xDEAD_BEEF; outstanding_o returns to 0.
- MaxOutstanding=4, up_req_i held high, up_rready_i=0, island always grants and responds -> exactly 4 grants; mem_req_o=0 afterwards; outstanding_o=4. Raise up_rready_i -> 4 responses in order, then one new grant per pop, each one cycle after its pop.
- Back-to-back traffic with a response push and upstream pop in every cycle -> fifo_cnt constant, no data loss; write responses (we=1) also produce up_rvalid_o.
- FallThrough=1, empty FIFO, up_rready_i=1, mem_rvalid_i=1 with data 0x1234 -> up_rvalid_o=1 and up_rdata_o=0x1234 in the same cycle; fifo_cnt stays 0.
- mem_rvalid_i with no request in flight -> err_o=1 next cycle and stays high; up_rvalid_o stays 0.
- Assert rst_i with 2 in flight and 1 buffered -> next cycle all outputs at reset values. A late mem_rvalid_i afterwards -> dropped and err_o=1.
